id_ex_stage: RTL and testbench

- ID/EX pipeline register of the MIPS-lite core; sits directly upstream of the ALU and drives its a, b and alu_op inputs.
- Captures decoded operands each cycle and forwards results from the MEM and WB stages into the operands.
- Detects load-use hazards and inserts one-cycle bubbles.
- Honours stall from downstream and flush on branch redirect.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS-lite core: captures decoded operands,
// forwards MEM/WB results into them, and inserts load-use bubbles.
module id_ex_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_IDX_W      = 5,
    parameter int ZEXT_LOGIC_IMM = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [DATA_W-1:0]    id_rs_val,
    input  logic [DATA_W-1:0]    id_rt_val,
    input  logic [15:0]          id_imm,
    input  logic                 id_use_imm,
    input  logic [3:0]           id_alu_op,
    input  logic                 id_reg_write,
    input  logic                 id_is_load,
    input  logic                 mem_reg_write,
    input  logic                 mem_is_load,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_result,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    ex_a,
    output logic [DATA_W-1:0]    ex_b,
    output logic [3:0]           ex_alu_op,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic                 ex_reg_write,
    output logic                 ex_is_load,
    output logic                 hazard_stall
);

    logic [REG_IDX_W-1:0] ex_rs;
    logic [REG_IDX_W-1:0] ex_rt;
    logic [DATA_W-1:0]    rs_q;
    logic [DATA_W-1:0]    rt_q;
    logic                 use_imm_q;

    logic [DATA_W-1:0]    fwd_a;
    logic [DATA_W-1:0]    fwd_b;
    logic [DATA_W-1:0]    cap_rs;
    logic [DATA_W-1:0]    cap_rt;
    logic [DATA_W-1:0]    imm_ext;
    logic                 load_use;

    // Operand forwarding on the stored values; MEM beats WB, r0 never forwarded.
    always_comb begin
        fwd_a = rs_q;
        if (mem_reg_write && !mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs))
            fwd_a = mem_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
            fwd_a = wb_data;

        fwd_b = rt_q;
        if (mem_reg_write && !mem_is_load && (mem_rd != '0) && (mem_rd == ex_rt))
            fwd_b = mem_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt))
            fwd_b = wb_data;
    end

    assign ex_a = fwd_a;
    assign ex_b = use_imm_q ? rt_q : fwd_b;

    // Register file write in the same cycle as the read is bypassed at capture.
    always_comb begin
        cap_rs = id_rs_val;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs))
            cap_rs = wb_data;

        cap_rt = id_rt_val;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt))
            cap_rt = wb_data;
    end

    always_comb begin
        if ((ZEXT_LOGIC_IMM != 0) && ((id_alu_op == 4'b0010) || (id_alu_op == 4'b0011)))
            imm_ext = {{(DATA_W-16){1'b0}}, id_imm};
        else
            imm_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};
    end

    always_comb begin
        load_use = ex_valid && ex_is_load && ex_reg_write && (ex_rd != '0) && id_valid &&
                   ((ex_rd == id_rs) || (!id_use_imm && (ex_rd == id_rt)));
        hazard_stall = load_use && !ex_stall && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            use_imm_q    <= 1'b0;
            ex_alu_op    <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (ex_stall) begin
            // Hold, but absorb any producer retiring now so it is not lost.
            rs_q <= fwd_a;
            if (!use_imm_q)
                rt_q <= fwd_b;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (hazard_stall) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            rs_q         <= cap_rs;
            rt_q         <= id_use_imm ? imm_ext : cap_rt;
            use_imm_q    <= id_use_imm;
            ex_alu_op    <= id_alu_op;
            ex_reg_write <= id_reg_write;
            ex_is_load   <= id_is_load;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a behavioural model
// of the EX register contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, ex_stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd;
    logic [31:0] id_rs_val, id_rt_val, mem_result, wb_data;
    logic [15:0] id_imm;
    logic        id_use_imm, id_reg_write, id_is_load;
    logic [3:0]  id_alu_op;
    logic        mem_reg_write, mem_is_load, wb_reg_write;
    logic        ex_valid, ex_reg_write, ex_is_load, hazard_stall;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;

    int total = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        bit        v;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsv, rtv, imm;
        bit        ui;
        bit [3:0]  op;
        bit        rw, ld;
    } mstate_t;

    mstate_t m;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_IDX_W(5), .ZEXT_LOGIC_IMM(1)) dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .hazard_stall(hazard_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // The value a register read sees this cycle: newest in-flight producer wins.
    function automatic bit [31:0] latest(input bit [4:0] r, input bit [31:0] stored);
        if (r == 0) return stored;
        if (mem_reg_write && !mem_is_load && mem_rd == r) return mem_result;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return stored;
    endfunction

    function automatic bit [31:0] ext(input bit [15:0] imm, input bit [3:0] op);
        if (op == 2 || op == 3) return {16'h0, imm};
        return imm[15] ? (32'hFFFF0000 | imm) : {16'h0, imm};
    endfunction

    function automatic bit model_hazard();
        bit dep;
        dep = (m.rd == id_rs) || (!id_use_imm && m.rd == id_rt);
        return m.v && m.ld && m.rw && m.rd != 0 && id_valid && dep && !ex_stall && !flush;
    endfunction

    function automatic mstate_t model_next();
        mstate_t n = m;
        if (rst) begin
            n = '{default: 0};
        end else if (ex_stall) begin
            n.rsv = latest(m.rs, m.rsv);
            if (!m.ui) n.rtv = latest(m.rt, m.rtv);
        end else if (flush) begin
            n.v = 0;
        end else if (model_hazard()) begin
            n.v  = 0;
            n.rw = 0;
        end else begin
            n.v   = id_valid;
            n.rs  = id_rs;
            n.rt  = id_rt;
            n.rd  = id_rd;
            n.rsv = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs) ? wb_data : id_rs_val;
            n.rtv = (wb_reg_write && wb_rd != 0 && wb_rd == id_rt) ? wb_data : id_rt_val;
            n.ui  = id_use_imm;
            n.imm = ext(id_imm, id_alu_op);
            n.op  = id_alu_op;
            n.rw  = id_reg_write;
            n.ld  = id_is_load;
        end
        return n;
    endfunction

    task automatic check_model();
        #1;
        chk("m_valid", ex_valid, m.v);
        chk("m_a", ex_a, latest(m.rs, m.rsv));
        chk("m_b", ex_b, m.ui ? m.imm : latest(m.rt, m.rtv));
        chk("m_op", ex_alu_op, m.op);
        chk("m_rd", ex_rd, m.rd);
        chk("m_rw", ex_reg_write, m.rw);
        chk("m_ld", ex_is_load, m.ld);
        chk("m_hz", hazard_stall, model_hazard());
    endtask

    task automatic step();
        mstate_t n;
        check_model();
        n = model_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic idle();
        rst = 0; ex_stall = 0; flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_use_imm = 0;
        id_alu_op = 0; id_reg_write = 0; id_is_load = 0;
        mem_reg_write = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                          input bit [31:0] rsv, input bit [31:0] rtv, input bit [15:0] imm,
                          input bit ui, input bit [3:0] op, input bit rw, input bit ld);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_imm = imm; id_use_imm = ui;
        id_alu_op = op; id_reg_write = rw; id_is_load = ld;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        m = '{default: 0};
        #1;
        rst = 0;
        #1;
        chk("reset_valid", ex_valid, 0);
        chk("reset_a", ex_a, 0);
        chk("reset_hz", hazard_stall, 0);

        // MEM vs WB priority on A
        idle(); set_id(1, 2, 3, 32'h111, 32'h222, 0, 0, 0, 1, 0); step();
        idle();
        mem_reg_write = 1; mem_rd = 1; mem_result = 32'h10;
        wb_reg_write = 1; wb_rd = 1; wb_data = 32'h20;
        #1 chk("fwd_mem", ex_a, 32'h10);
        mem_reg_write = 0;
        #1 chk("fwd_wb", ex_a, 32'h20);
        wb_reg_write = 0;
        #1 chk("fwd_none_a", ex_a, 32'h111);
        chk("fwd_none_b", ex_b, 32'h222);
        step();

        // register 0 never forwarded
        idle(); set_id(0, 0, 3, 32'h55, 32'h66, 0, 0, 0, 1, 0); step();
        idle();
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'h99;
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'h88;
        #1 chk("r0_a", ex_a, 32'h55);
        step();

        // immediate extension
        idle(); set_id(1, 2, 3, 0, 0, 16'hFFFF, 1, 4'b0000, 1, 0); step();
        idle(); #1 chk("imm_sext", ex_b, 32'hFFFFFFFF);
        set_id(1, 2, 3, 0, 0, 16'hFFFF, 1, 4'b0011, 1, 0); step();
        idle(); #1 chk("imm_zext", ex_b, 32'h0000FFFF);

        // load-use: lw r5 then add r6,r5,r4
        idle(); set_id(1, 0, 5, 0, 0, 0, 1, 0, 1, 1); step();
        set_id(5, 4, 6, 32'h777, 32'h444, 0, 0, 0, 1, 0);
        #1 chk("lu_hz", hazard_stall, 1);
        step();
        mem_reg_write = 1; mem_is_load = 1; mem_rd = 5; mem_result = 32'h1234;
        #1 chk("lu_bubble", ex_valid, 0);
        chk("lu_hz_once", hazard_stall, 0);
        step();
        idle(); wb_reg_write = 1; wb_rd = 5; wb_data = 32'hDEAD;
        #1 chk("lu_valid", ex_valid, 1);
        chk("lu_a", ex_a, 32'hDEAD);
        chk("lu_b", ex_b, 32'h444);
        step();

        // stall refresh keeps a producer that retires mid-hold
        idle(); set_id(1, 2, 3, 32'h1, 32'h2, 0, 0, 0, 1, 0); step();
        idle(); ex_stall = 1; wb_reg_write = 1; wb_rd = 1; wb_data = 32'hABCD; step();
        wb_reg_write = 0; step(); step();
        #1 chk("stall_refresh", ex_a, 32'hABCD);
        chk("stall_valid", ex_valid, 1);
        step();

        // flush together with a load-use condition
        idle(); set_id(1, 0, 5, 0, 0, 0, 1, 0, 1, 1); step();
        set_id(5, 4, 6, 0, 0, 0, 0, 0, 1, 0); flush = 1;
        #1 chk("flush_hz", hazard_stall, 0);
        step();
        chk("flush_valid", ex_valid, 0);

        // reset mid-operation
        idle(); set_id(1, 2, 3, 32'h5, 32'h6, 0, 0, 0, 1, 0); step();
        rst = 1; step();
        idle();
        #1 chk("rst_mid_valid", ex_valid, 0);
        chk("rst_mid_a", ex_a, 0);
        chk("rst_mid_b", ex_b, 0);
        chk("rst_mid_hz", hazard_stall, 0);

        // randomized traffic with narrow register indices to provoke hits
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            ex_stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 10);
            id_valid = $urandom_range(0, 1);
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_rs_val = $urandom; id_rt_val = $urandom;
            id_imm = 16'($urandom);
            id_use_imm = $urandom_range(0, 1);
            id_alu_op = 4'($urandom_range(0, 3));
            id_reg_write = $urandom_range(0, 1);
            id_is_load = $urandom_range(0, 1);
            mem_reg_write = $urandom_range(0, 1);
            mem_is_load = $urandom_range(0, 1);
            mem_rd = 5'($urandom_range(0, 7));
            mem_result = $urandom;
            wb_reg_write = $urandom_range(0, 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
